uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
Serial receive front end of the uart_16550. Takes the raw RXD pin and the line-control fields from the register block. Synchronises the line, detects and validates the start bit, and mid-bit samples 5–8 data bits, optional parity and the stop bit. Delivers one character per frame, with parity, framing and break status, to the RX FIFO/LSR logic in the register block.

Parameters:
MIN_DIV, 16'd4, smallest honoured bit period; smaller div values are treated as MIN_DIV

Ports:
PCLK  input  1  system clock, also the APB clock
PRESET  input  1  asynchronous, active-high reset
rxd  input  1  raw serial line, asynchronous, idle high
div  input  16  bit period in PCLK cycles (434 = 115200 baud at 50 MHz)
wls  input  2  word length select: 0→5, 1→6, 2→7, 3→8 bits
pen  input  1  parity enable
eps  input  1  even parity select
sp  input  1  stick parity
rx_data  output  8  received character, LSB first, zero-extended above word length
rx_valid  output  1  one-cycle strobe: rx_data/pe/fe/bi are valid
pe  output  1  parity error for the current character
fe  output  1  framing error (first stop bit sampled 0)
bi  output  1  break: data, parity and stop all sampled 0
busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset (async, PRESET=1):
  - state=IDLE; synchroniser flops are set to 1.
  - rx_data=0, rx_valid=0, pe=0, fe=0, bi=0, busy=0.
  - Reset mid-frame abandons the frame with no strobe.
- Synchroniser: two flops on rxd. All logic uses the output rxd_s (2-cycle latency).
- Configuration latch:
  - div (clamped to ≥MIN_DIV), wls, pen, eps, sp are latched in the cycle a start is detected.
  - Changes during a frame take effect from the next frame.
- Bit counter: 16-bit down-counter. Half = latched_div>>1.
- States: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - IDLE: first cycle with rxd_s=0 (cycle k0): latch config, load counter with Half-1, busy=1, go to START.
  - START: at counter expiry (cycle k0+Half), sample rxd_s.
    - 1 → false start: return to IDLE, no strobe.
    - 0 → reload div-1, bit index=0, go to DATA.
  - DATA: at each expiry (sample points k0+Half+div·(i+1)), shift rxd_s in at bit i. After bit N-1 (N = 5+wls), go to PARITY if pen, else STOP.
  - PARITY: sample once at expiry and store.
    - Expected parity bit: sp=0,eps=1 → XOR(data); sp=0,eps=0 → ~XOR(data); sp=1,eps=0 → 1; sp=1,eps=1 → 0.
    - pe = sampled ≠ expected.
  - STOP: sample the first stop bit only.
    - fe = ~rxd_s.
    - bi = data all 0 AND (parity bit 0 or pen=0) AND stop 0.
    - If bi, go to BRKWAIT; else go to IDLE.
- Output registers:
  - rx_data/pe/fe/bi update, and rx_valid pulses, in the cycle after the stop sample (k0+Half+div·(N+1+pen)+1).
  - pe/fe/bi/rx_data hold until the next strobe.
- Stop-bit handling:
  - A new start can be detected in the cycle after returning to IDLE.
  - The second stop bit (when configured) is not checked.
  - fe without bi (stop sampled 0, data nonzero) returns directly to IDLE. The low line is then immediately seen as a new start, matching 16550 resynchronisation.
- BRKWAIT: hold busy=1 until rxd_s=1, then go to IDLE. Exactly one break character is reported per break.
- Timing and output width:
  - div odd: Half rounds down. Expiry tolerance is exact; there is no jitter or drift between bits.
  - rx_data bits ≥N are forced to 0.

Test Plan:
- div=434, wls=3, pen=1, eps=0, sp=0; send 0x6B with parity bit 0, one stop → single rx_valid at k0+217+434·10+1, rx_data=0x6B, pe=0, fe=0, bi=0.
- Same config, 0x6B with parity bit 1 → rx_data=0x6B, pe=1, fe=0.
- div=434, wls=3, pen=0; send 0xC3 8N1 back-to-back with 0x5A (no idle gap) → two strobes with 0xC3 then 0x5A, no errors, busy never drops for more than 1 bit time.
- div=434, wls=0, pen=1, sp=1, eps=0; send 5-bit 0x15, parity bit 1 → rx_data=0x15, pe=0. Repeat with parity bit 0 → pe=1.
- Hold rxd low for 12 bit times, 8N1 → one strobe, rx_data=0x00, fe=1, bi=1, busy high until rxd returns high, no second strobe. A 100-cycle low glitch at div=434 → no strobe, busy drops at k0+217.
- Assert PRESET during DATA of a frame → outputs return to reset values asynchronously, no strobe. Next clean frame 0xA7 is received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises RXD, validates the start bit, mid-bit samples
// 5-8 data bits, optional parity and the first stop bit, and reports one character per frame.
module uart_rx_deframer #(
  parameter logic [15:0] MIN_DIV = 16'd4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        rxd,
  input  logic [15:0] div,
  input  logic [1:0]  wls,
  input  logic        pen,
  input  logic        eps,
  input  logic        sp,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        pe,
  output logic        fe,
  output logic        bi,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        par_bit_q, par_bit_d;

  // Line configuration captured at start detection, held for the whole frame
  logic [15:0] div_q, div_d;
  logic [1:0]  wls_q, wls_d;
  logic        pen_q, pen_d;
  logic        eps_q, eps_d;
  logic        sp_q, sp_d;

  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        pe_q, pe_d;
  logic        fe_q, fe_d;
  logic        bi_q, bi_d;

  logic        rxd_s;
  logic        expiry;
  logic [15:0] div_clamped;
  logic [2:0]  last_idx;
  logic [7:0]  data_mask;
  logic        exp_par;
  logic        brk;

  assign rxd_s       = sync_q[1];
  assign sync_d      = {sync_q[0], rxd};
  assign expiry      = (cnt_q == 16'd0);
  assign div_clamped = (div < MIN_DIV) ? MIN_DIV : div;
  assign last_idx    = 3'd4 + {1'b0, wls_q};
  assign data_mask   = 8'hFF >> (2'd3 - wls_q);
  // Stick parity forces the bit to ~eps; otherwise even/odd over the data bits
  assign exp_par     = sp_q ? ~eps_q : (eps_q ? ^data_q : ~(^data_q));
  assign brk         = (data_q == 8'd0) && (!pen_q || !par_bit_q) && !rxd_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    div_d      = div_q;
    wls_d      = wls_q;
    pen_d      = pen_q;
    eps_d      = eps_q;
    sp_d       = sp_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    pe_d       = pe_q;
    fe_d       = fe_q;
    bi_d       = bi_q;

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          div_d     = div_clamped;
          wls_d     = wls;
          pen_d     = pen;
          eps_d     = eps;
          sp_d      = sp;
          cnt_d     = (div_clamped >> 1) - 16'd1;
          data_d    = 8'd0;
          par_bit_d = 1'b0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (!expiry) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rxd_s) begin
          state_d = S_IDLE;
        end else begin
          cnt_d     = div_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (!expiry) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          data_d[bit_idx_q] = rxd_s;
          cnt_d             = div_q - 16'd1;
          if (bit_idx_q == last_idx) begin
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (!expiry) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          par_bit_d = rxd_s;
          cnt_d     = div_q - 16'd1;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (!expiry) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          rx_valid_d = 1'b1;
          rx_data_d  = data_q & data_mask;
          pe_d       = pen_q && (par_bit_q != exp_par);
          fe_d       = !rxd_s;
          bi_d       = brk;
          // A framing error without break returns straight to IDLE so a low line resyncs as a start
          state_d    = brk ? S_BRKWAIT : S_IDLE;
        end
      end

      S_BRKWAIT: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'd0;
      par_bit_q  <= 1'b0;
      div_q      <= MIN_DIV;
      wls_q      <= 2'd0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bi_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      div_q      <= div_d;
      wls_q      <= wls_d;
      pen_q      <= pen_d;
      eps_q      <= eps_d;
      sp_q       <= sp_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      bi_q       <= bi_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign pe       = pe_q;
  assign fe       = fe_q;
  assign bi       = bi_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: frames are driven bit by bit and every strobe is
// logged with its cycle number, then checked against hand-computed values.
module tb_uart_rx_deframer;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        rxd;
  logic [15:0] div;
  logic [1:0]  wls;
  logic        pen;
  logic        eps;
  logic        sp;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pe;
  logic        fe;
  logic        bi;
  logic        busy;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
    int         cyc;
  } strobe_t;

  strobe_t strobes[$];
  strobe_t mon_s;
  bit      track_busy   = 1'b0;
  int      busy_low_run = 0;
  int      busy_low_max = 0;

  uart_rx_deframer #(.MIN_DIV(16'd4)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .rxd      (rxd),
    .div      (div),
    .wls      (wls),
    .pen      (pen),
    .eps      (eps),
    .sp       (sp),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pe       (pe),
    .fe       (fe),
    .bi       (bi),
    .busy     (busy)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (rx_valid) begin
      mon_s.data = rx_data;
      mon_s.pe   = pe;
      mon_s.fe   = fe;
      mon_s.bi   = bi;
      mon_s.cyc  = cyc;
      strobes.push_back(mon_s);
      $display("strobe cyc=%0d data=%02h pe=%0b fe=%0b bi=%0b", cyc, rx_data, pe, fe, bi);
    end
    if (track_busy) begin
      if (!busy) begin
        busy_low_run = busy_low_run + 1;
        if (busy_low_run > busy_low_max) busy_low_max = busy_low_run;
      end else begin
        busy_low_run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Drives start, n data bits LSB first, optional parity and one stop bit; c is the cycle rxd fell
  task automatic send_frame(input logic [7:0] d, input int n, input bit use_par,
                            input bit par, input int per, output int c);
    c   = cyc;
    rxd = 1'b0;
    tick(per);
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      tick(per);
    end
    if (use_par) begin
      rxd = par;
      tick(per);
    end
    rxd = 1'b1;
    tick(per);
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    rxd    = 1'b1;
    div    = 16'd434;
    wls    = 2'd3;
    pen    = 1'b0;
    eps    = 1'b0;
    sp     = 1'b0;
    tick(3);
    check_cnt++;
    if ({rx_data, rx_valid, pe, fe, bi, busy} !== 13'd0)
      $display("FAIL reset_outputs got=%h want=0", {rx_data, rx_valid, pe, fe, bi, busy});
    else pass_cnt++;
    PRESET = 1'b0;
    tick(5);
    check_cnt++;
    if (busy !== 1'b0 || strobes.size() != 0)
      $display("FAIL reset_idle busy=%0b strobes=%0d want busy=0 strobes=0", busy, strobes.size());
    else pass_cnt++;
  endtask

  task automatic test_parity_odd();
    int c;
    int exp_cyc;
    div = 16'd434; wls = 2'd3; pen = 1'b1; eps = 1'b0; sp = 1'b0;
    for (int p = 0; p < 2; p++) begin
      strobes.delete();
      send_frame(8'h6B, 8, 1'b1, p[0], 434, c);
      tick(434);
      exp_cyc = c + 3 + 217 + 434 * 10;
      check_cnt++;
      if (strobes.size() != 1) begin
        $display("FAIL odd_par%0d_count got=%0d want=1", p, strobes.size());
      end else begin
        pass_cnt++;
        check_cnt++;
        if (strobes[0].data !== 8'h6B || strobes[0].pe !== p[0] ||
            strobes[0].fe !== 1'b0 || strobes[0].bi !== 1'b0)
          $display("FAIL odd_par%0d_status got data=%02h pe=%0b fe=%0b bi=%0b want data=6b pe=%0b fe=0 bi=0",
                   p, strobes[0].data, strobes[0].pe, strobes[0].fe, strobes[0].bi, p[0]);
        else pass_cnt++;
        check_cnt++;
        if (strobes[0].cyc != exp_cyc)
          $display("FAIL odd_par%0d_timing got=%0d want=%0d", p, strobes[0].cyc, exp_cyc);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    div = 16'd434; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    strobes.delete();
    busy_low_run = 0;
    busy_low_max = 0;
    track_busy   = 1'b1;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 434, c1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 434, c2);
    track_busy = 1'b0;
    tick(434);
    check_cnt++;
    if (strobes.size() != 2) begin
      $display("FAIL b2b_count got=%0d want=2", strobes.size());
    end else begin
      pass_cnt++;
      check_cnt++;
      if (strobes[0].data !== 8'hC3 || strobes[1].data !== 8'h5A)
        $display("FAIL b2b_data got=%02h,%02h want=c3,5a", strobes[0].data, strobes[1].data);
      else pass_cnt++;
      check_cnt++;
      if ({strobes[0].pe, strobes[0].fe, strobes[0].bi, strobes[1].pe, strobes[1].fe, strobes[1].bi} !== 6'd0)
        $display("FAIL b2b_errors got=%b want=000000",
                 {strobes[0].pe, strobes[0].fe, strobes[0].bi, strobes[1].pe, strobes[1].fe, strobes[1].bi});
      else pass_cnt++;
      check_cnt++;
      if (strobes[1].cyc != c2 + 3 + 217 + 434 * 9)
        $display("FAIL b2b_timing got=%0d want=%0d", strobes[1].cyc, c2 + 3 + 217 + 434 * 9);
      else pass_cnt++;
    end
    check_cnt++;
    if (busy_low_max > 434)
      $display("FAIL b2b_busy_gap got=%0d want<=434", busy_low_max);
    else pass_cnt++;
  endtask

  task automatic test_stick_parity();
    int c;
    div = 16'd434; wls = 2'd0; pen = 1'b1; eps = 1'b0; sp = 1'b1;
    for (int p = 1; p >= 0; p--) begin
      strobes.delete();
      send_frame(8'h15, 5, 1'b1, p[0], 434, c);
      tick(434);
      check_cnt++;
      if (strobes.size() != 1) begin
        $display("FAIL stick_par%0d_count got=%0d want=1", p, strobes.size());
      end else begin
        pass_cnt++;
        check_cnt++;
        if (strobes[0].data !== 8'h15 || strobes[0].pe !== ~p[0] || strobes[0].fe !== 1'b0)
          $display("FAIL stick_par%0d_status got data=%02h pe=%0b fe=%0b want data=15 pe=%0b fe=0",
                   p, strobes[0].data, strobes[0].pe, strobes[0].fe, ~p[0]);
        else pass_cnt++;
        check_cnt++;
        if (strobes[0].cyc != c + 3 + 217 + 434 * 7)
          $display("FAIL stick_par%0d_timing got=%0d want=%0d", p, strobes[0].cyc, c + 3 + 217 + 434 * 7);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_min_div();
    int c;
    div = 16'd1; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    strobes.delete();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 4, c);
    tick(20);
    check_cnt++;
    if (strobes.size() != 1) begin
      $display("FAIL min_div_count got=%0d want=1", strobes.size());
    end else begin
      pass_cnt++;
      check_cnt++;
      if (strobes[0].data !== 8'h3C || strobes[0].cyc != c + 3 + 2 + 4 * 9)
        $display("FAIL min_div_frame got data=%02h cyc=%0d want data=3c cyc=%0d",
                 strobes[0].data, strobes[0].cyc, c + 3 + 2 + 4 * 9);
      else pass_cnt++;
    end
  endtask

  task automatic test_break();
    int c;
    div = 16'd434; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    strobes.delete();
    c   = cyc;
    rxd = 1'b0;
    tick(12 * 434);
    check_cnt++;
    if (busy !== 1'b1)
      $display("FAIL break_busy_held got=%0b want=1", busy);
    else pass_cnt++;
    rxd = 1'b1;
    tick(5);
    check_cnt++;
    if (busy !== 1'b0)
      $display("FAIL break_busy_release got=%0b want=0", busy);
    else pass_cnt++;
    tick(1000);
    check_cnt++;
    if (strobes.size() != 1) begin
      $display("FAIL break_count got=%0d want=1", strobes.size());
    end else begin
      pass_cnt++;
      check_cnt++;
      if (strobes[0].data !== 8'h00 || strobes[0].fe !== 1'b1 || strobes[0].bi !== 1'b1 ||
          strobes[0].cyc != c + 3 + 217 + 434 * 9)
        $display("FAIL break_status got data=%02h fe=%0b bi=%0b cyc=%0d want data=00 fe=1 bi=1 cyc=%0d",
                 strobes[0].data, strobes[0].fe, strobes[0].bi, strobes[0].cyc, c + 3 + 217 + 434 * 9);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    div = 16'd434; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    strobes.delete();
    rxd = 1'b0;
    tick(100);
    rxd = 1'b1;
    tick(119);
    check_cnt++;
    if (busy !== 1'b1)
      $display("FAIL glitch_busy_before_sample got=%0b want=1", busy);
    else pass_cnt++;
    tick(3);
    check_cnt++;
    if (busy !== 1'b0)
      $display("FAIL glitch_busy_after_sample got=%0b want=0", busy);
    else pass_cnt++;
    tick(500);
    check_cnt++;
    if (strobes.size() != 0)
      $display("FAIL glitch_no_strobe got=%0d want=0", strobes.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int c;
    logic [7:0] d;
    div = 16'd434; wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    d = 8'hA7;
    strobes.delete();
    rxd = 1'b0;
    tick(434);
    for (int i = 0; i < 3; i++) begin
      rxd = d[i];
      tick(434);
    end
    check_cnt++;
    if (busy !== 1'b1 || fe !== 1'b1 || bi !== 1'b1)
      $display("FAIL pre_reset_state got busy=%0b fe=%0b bi=%0b want 1 1 1", busy, fe, bi);
    else pass_cnt++;
    #2;
    PRESET = 1'b1;
    rxd    = 1'b1;
    #1;
    check_cnt++;
    if ({rx_data, rx_valid, pe, fe, bi, busy} !== 13'd0)
      $display("FAIL async_reset_outputs got=%h want=0", {rx_data, rx_valid, pe, fe, bi, busy});
    else pass_cnt++;
    tick(4);
    PRESET = 1'b0;
    tick(2000);
    check_cnt++;
    if (strobes.size() != 0)
      $display("FAIL reset_no_strobe got=%0d want=0", strobes.size());
    else pass_cnt++;
    send_frame(8'hA7, 8, 1'b0, 1'b0, 434, c);
    tick(434);
    check_cnt++;
    if (strobes.size() != 1 || strobes[0].data !== 8'hA7 || strobes[0].fe !== 1'b0 ||
        strobes[0].bi !== 1'b0 || strobes[0].pe !== 1'b0)
      $display("FAIL post_reset_frame got count=%0d data=%02h want count=1 data=a7 no errors",
               strobes.size(), (strobes.size() > 0) ? strobes[0].data : 8'h00);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_parity_odd();
    tick(50);
    test_back_to_back();
    tick(50);
    test_stick_parity();
    tick(50);
    test_min_div();
    tick(50);
    test_break();
    tick(50);
    test_glitch();
    tick(50);
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
